// File: rtl/bsg_locking_arb_pkg.sv
// Shared types and helpers for the counted round-robin locking arbiter.
package bsg_locking_arb_pkg;

    typedef enum logic {e_idle, e_locked} state_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_locking_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr_i, wrapping.
module bsg_locking_arb_rr_pick
    import bsg_locking_arb_pkg::*;
#(
    parameter int unsigned inputs_p = 1
) (
    input  logic [inputs_p-1:0]                reqs_i,
    input  logic [safe_clog2(inputs_p)-1:0]    rr_ptr_i,
    output logic [inputs_p-1:0]                grant_o,
    output logic [safe_clog2(inputs_p)-1:0]    winner_o
);

    localparam int unsigned ptr_w_lp = safe_clog2(inputs_p);

    logic [ptr_w_lp-1:0] idx;
    logic                found;

    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < inputs_p; i++) begin
            idx = ptr_w_lp'((32'(rr_ptr_i) + i) % inputs_p);
            if (!found && reqs_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                winner_o     = idx;
            end
        end
    end

endmodule

// File: rtl/bsg_locking_arb_rr_counted.sv
// Round-robin locking arbiter: holds a multi-beat winner for a length-counted burst,
// releasing on the last beat, an explicit unlock, or an idle-owner timeout.
module bsg_locking_arb_rr_counted
    import bsg_locking_arb_pkg::*;
#(
    parameter int unsigned inputs_p    = 1,
    parameter int unsigned len_width_p = 4,
    parameter int unsigned timeout_p   = 0
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              ready_i,
    input  logic [inputs_p-1:0]               reqs_i,
    input  logic [inputs_p*len_width_p-1:0]   len_i,
    input  logic                              unlock_i,
    output logic [inputs_p-1:0]               grants_o,
    output logic                              locked_o,
    output logic [safe_clog2(inputs_p)-1:0]   owner_o,
    output logic                              timeout_o
);

    localparam int unsigned ptr_w_lp = safe_clog2(inputs_p);
    localparam int unsigned cnt_w_lp = safe_clog2(timeout_p + 1);

    localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(inputs_p - 1);
    localparam logic [cnt_w_lp-1:0] cnt_max_lp  = cnt_w_lp'(timeout_p);
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'((timeout_p > 0) ? timeout_p - 1 : 0);

    state_e                 state_q, state_d;
    logic [ptr_w_lp-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ptr_w_lp-1:0]    owner_q, owner_d;
    logic [len_width_p-1:0] remaining_q, remaining_d;
    logic [cnt_w_lp-1:0]    idle_cnt_q, idle_cnt_d;
    logic                   timeout_q, timeout_d;

    logic [inputs_p-1:0]    pick_grant;
    logic [ptr_w_lp-1:0]    pick_winner;
    logic [len_width_p-1:0] winner_len;
    logic [inputs_p-1:0]    owner_onehot;
    logic                   owner_req;
    logic                   xfer;
    logic                   timeout_hit;

    bsg_locking_arb_rr_pick #(
        .inputs_p (inputs_p)
    ) u_pick (
        .reqs_i   (reqs_i),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (pick_grant),
        .winner_o (pick_winner)
    );

    always_comb begin
        winner_len   = '0;
        owner_onehot = '0;
        for (int unsigned k = 0; k < inputs_p; k++) begin
            if (pick_winner == ptr_w_lp'(k)) begin
                winner_len = len_i[k*len_width_p +: len_width_p];
            end
            if (owner_q == ptr_w_lp'(k)) begin
                owner_onehot[k] = 1'b1;
            end
        end
    end

    assign owner_req = |(owner_onehot & reqs_i);

    always_comb begin
        grants_o = '0;
        if (ready_i) begin
            grants_o = (state_q == e_idle) ? pick_grant : (owner_onehot & reqs_i);
        end
    end

    assign xfer        = ready_i & (|grants_o);
    assign timeout_hit = (timeout_p != 0) && !owner_req && (idle_cnt_q == cnt_last_lp);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        remaining_d = remaining_q;
        idle_cnt_d  = idle_cnt_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            e_idle: begin
                if (xfer) begin
                    rr_ptr_d = (pick_winner == ptr_last_lp) ? '0 : pick_winner + 1'b1;
                    if (winner_len != '0 && !unlock_i) begin
                        state_d     = e_locked;
                        owner_d     = pick_winner;
                        remaining_d = winner_len;
                        idle_cnt_d  = '0;
                    end
                end
            end
            e_locked: begin
                if (xfer) begin
                    remaining_d = remaining_q - 1'b1;
                end
                if (owner_req) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != cnt_max_lp) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                // Release priority: unlock, then timeout, then last beat.
                if (unlock_i) begin
                    state_d = e_idle;
                end else if (timeout_hit) begin
                    state_d   = e_idle;
                    timeout_d = 1'b1;
                end else if (xfer && remaining_q == len_width_p'(1)) begin
                    state_d = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= e_idle;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            remaining_q <= '0;
            idle_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            remaining_q <= remaining_d;
            idle_cnt_q  <= idle_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign locked_o  = (state_q == e_locked);
    assign owner_o   = owner_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_bsg_locking_arb_rr_counted.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// checked every cycle against a burst-level behavioural model.
module tb_bsg_locking_arb_rr_counted;

    localparam int N  = 4;
    localparam int LW = 4;
    localparam int TO = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            ready;
    logic            unlock;
    logic [N-1:0]    reqs;
    logic [N*LW-1:0] lens;
    logic [N-1:0]    grants;
    logic            locked;
    logic [1:0]      owner;
    logic            tout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_locking_arb_rr_counted #(
        .inputs_p    (N),
        .len_width_p (LW),
        .timeout_p   (TO)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .ready_i   (ready),
        .reqs_i    (reqs),
        .len_i     (lens),
        .unlock_i  (unlock),
        .grants_o  (grants),
        .locked_o  (locked),
        .owner_o   (owner),
        .timeout_o (tout)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Burst-level model: a burst is len+1 beats; count beats done and idle owner cycles.
    bit m_ok = 1'b0;
    bit m_locked;
    int m_owner, m_ptr, m_total, m_done, m_idle;
    bit m_tpulse;

    function automatic int len_of(input int k);
        return int'(lens[k*LW +: LW]);
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (!ready) return g;
        if (m_locked) begin
            if (reqs[m_owner]) g[m_owner] = 1'b1;
            return g;
        end
        for (int i = 0; i < N; i++) begin
            if (reqs[(m_ptr + i) % N]) begin
                g[(m_ptr + i) % N] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] eg;
        int w;
        bit oreq;
        eg = exp_grant();
        if (m_ok) begin
            chk("grants", 32'(grants), 32'(eg));
            chk("locked", 32'(locked), 32'(m_locked));
            chk("owner", 32'(owner), 32'(m_owner));
            chk("timeout", 32'(tout), 32'(m_tpulse));
        end
        if (!reset_n) begin
            m_ok = 1'b1; m_locked = 1'b0; m_owner = 0; m_ptr = 0;
            m_total = 0; m_done = 0; m_idle = 0; m_tpulse = 1'b0;
        end else if (m_ok) begin
            w = 0;
            for (int i = 0; i < N; i++) if (eg[i]) w = i;
            m_tpulse = 1'b0;
            if (!m_locked) begin
                if (eg != '0) begin
                    m_ptr = (w + 1) % N;
                    if (len_of(w) != 0 && !unlock) begin
                        m_locked = 1'b1; m_owner = w;
                        m_total = len_of(w) + 1; m_done = 1; m_idle = 0;
                    end
                end
            end else begin
                oreq = reqs[m_owner];
                if (eg != '0) m_done++;
                m_idle = oreq ? 0 : m_idle + 1;
                if (unlock) m_locked = 1'b0;
                else if (TO > 0 && !oreq && m_idle >= TO) begin
                    m_locked = 1'b0; m_tpulse = 1'b1;
                end else if (m_done == m_total) m_locked = 1'b0;
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; literal checks sample 2 units later.
    task automatic drive(input logic [N-1:0] r, input logic rd, input logic ul);
        reqs = r; ready = rd; unlock = ul;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int k, input int v);
        lens[k*LW +: LW] = LW'(v);
    endtask

    initial begin
        logic [N-1:0] rr_exp [8];
        logic [N-1:0] stall_g [6];
        logic         stall_rdy [6];
        rr_exp    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        stall_g   = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100};
        stall_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        reset_n = 1'b0; reqs = '0; ready = 1'b1; unlock = 1'b0; lens = '0;
        #1;
        next_cycle(); next_cycle();
        reset_n = 1'b1;
        drive(4'b0000, 1'b1, 1'b0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_timeout", 32'(tout), 0);
        next_cycle();

        // Round robin over single-beat bursts.
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, 1'b1, 1'b0);
            chk("rr_grant", 32'(grants), 32'(rr_exp[c]));
            chk("rr_locked", 32'(locked), 0);
            next_cycle();
        end

        // 4-beat burst on input 2, then input 0 with no bubble.
        set_len(2, 3);
        drive(4'b0100, 1'b1, 1'b0);
        chk("burst_first", 32'(grants), 32'h4);
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0101, 1'b1, 1'b0);
            chk("burst_grant", 32'(grants), 32'h4);
            chk("burst_locked", 32'(locked), 1);
            next_cycle();
        end
        drive(4'b0101, 1'b1, 1'b0);
        chk("burst_after", 32'(grants), 32'h1);
        chk("burst_unlocked", 32'(locked), 0);
        next_cycle();

        // Stall the same burst with ready 1,0,0,1,1,1.
        for (int c = 0; c < 6; c++) begin
            drive((c == 0) ? 4'b0100 : 4'b0101, stall_rdy[c], 1'b0);
            chk("stall_grant", 32'(grants), 32'(stall_g[c]));
            if (c > 0) chk("stall_locked", 32'(locked), 1);
            next_cycle();
        end
        drive(4'b0000, 1'b1, 1'b0);
        chk("stall_done", 32'(locked), 0);
        next_cycle();

        // Unlock on the second beat; arbitration resumes at owner+1.
        drive(4'b0100, 1'b1, 1'b0);
        chk("unl_first", 32'(grants), 32'h4);
        next_cycle();
        drive(4'b1111, 1'b1, 1'b1);
        chk("unl_beat2", 32'(grants), 32'h4);
        next_cycle();
        drive(4'b1111, 1'b1, 1'b0);
        chk("unl_locked", 32'(locked), 0);
        chk("unl_resume", 32'(grants), 32'h8);
        next_cycle();

        // Owner goes quiet after beat 1: forced release after TO idle cycles.
        drive(4'b0100, 1'b1, 1'b0);
        chk("to_first", 32'(grants), 32'h4);
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0001, 1'b1, 1'b0);
            chk("to_wait_grant", 32'(grants), 0);
            chk("to_wait_locked", 32'(locked), 1);
            chk("to_wait_pulse", 32'(tout), 0);
            next_cycle();
        end
        drive(4'b0001, 1'b1, 1'b0);
        chk("to_pulse", 32'(tout), 1);
        chk("to_released", 32'(locked), 0);
        chk("to_other", 32'(grants), 32'h1);
        next_cycle();
        drive(4'b0000, 1'b1, 1'b0);
        chk("to_pulse_end", 32'(tout), 0);
        next_cycle();

        // Reset mid-burst drops the lock and rewinds the pointer.
        drive(4'b0100, 1'b1, 1'b0);
        next_cycle();
        drive(4'b0100, 1'b1, 1'b0);
        next_cycle();
        reset_n = 1'b0;
        drive(4'b0100, 1'b1, 1'b0);
        chk("mid_rst_locked", 32'(locked), 1);
        next_cycle();
        reset_n = 1'b1;
        drive(4'b1000, 1'b1, 1'b0);
        chk("post_rst_locked", 32'(locked), 0);
        chk("post_rst_owner", 32'(owner), 0);
        chk("post_rst_tout", 32'(tout), 0);
        chk("post_rst_grant", 32'(grants), 32'h8);
        next_cycle();

        // Random traffic; the negedge process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                set_len(k, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 5));
                reqs[k] = ($urandom_range(0, 9) < 7);
            end
            ready   = ($urandom_range(0, 3) != 0);
            unlock  = ($urandom_range(0, 24) == 0);
            reset_n = ($urandom_range(0, 199) != 0);
            next_cycle();
        end
        reset_n = 1'b1; reqs = '0; unlock = 1'b0;
        next_cycle();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
